// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file: reset polarity, enables and bus widths.
package regfile_pkg;

    localparam logic RstEnable   = 1'b0;
    localparam logic RstDisable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/regfile_if.sv
// Write-back triple from mem_wb plus the two decode-stage read ports.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: reset gate, $0 gate, write-back bypass, then array value.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if (rst == RstEnable) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
        end else if (re == ReadEnable && we == WriteEnable && waddr == raddr) begin
            // Write-back lands this edge; hand decode the new value now.
            rdata = wdata;
        end else if (re == ReadEnable) begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32 MIPS register file: synchronous write, two bypassed combinational reads, $0 fixed at zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RegNum,
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegNumLog2
) (
    input logic     clk,
    input logic     rst,
    regfile_if.slave rf
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rst == RstDisable && rf.we == WriteEnable && rf.waddr != '0) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    regfile_rdport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rdport1 (
        .rst    (rst),
        .re     (rf.re1),
        .raddr  (rf.raddr1),
        .we     (rf.we),
        .waddr  (rf.waddr),
        .wdata  (rf.wdata),
        .stored (regs[rf.raddr1]),
        .rdata  (rf.rdata1)
    );

    regfile_rdport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rdport2 (
        .rst    (rst),
        .re     (rf.re2),
        .raddr  (rf.raddr2),
        .we     (rf.we),
        .waddr  (rf.waddr),
        .wdata  (rf.wdata),
        .stored (regs[rf.raddr2]),
        .rdata  (rf.rdata2)
    );

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file. It is the write-back end of the pipeline's write-destination interface: it consumes the (write address, write enable, write data) triple that execute produces, after that triple has passed through the ex_mem, mem and mem_wb stages.
- Supplies the two operand reads required by the decode stage.
- Register $0 is hardwired to zero.
- Write-to-read bypass inside the file resolves the decode/write-back same-cycle hazard.

Parameters:
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
- DATA_W, 32, register width (`RegBus).
- ADDR_W, 5, register address width (`RegAddrBus).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low: asserted when 0, sampled on clk rising edge.
- we  input  1  write enable, from mem_wb wreg.
- waddr  input  ADDR_W  write address, from mem_wb wd.
- wdata  input  DATA_W  write data, from mem_wb wdata.
- re1  input  1  read port 1 enable, from decode.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data, combinational.

Behaviour:
- Storage: array regs[0..NUM_REGS-1], updated only on the clk rising edge.
- Reset (rst==0 at the edge):
  - All regs cleared to 0x00000000.
  - Any concurrent write is discarded.
  - While rst==0, rdata1 and rdata2 are forced to 0, regardless of re, bypass or array contents.
- Write (rst==1, we==1, waddr!=0): regs[waddr] <= wdata at the edge. Write latency is 1 cycle; the new value is visible in the array from the next cycle.
- Write to $0 (waddr==0): ignored, and regs[0] stays 0 permanently.
- Write with we==0: no state change, whatever waddr/wdata are.
- Read port n (same rule for ports 1 and 2), evaluated in priority order:
  1. rst==0 -> 0.
  2. raddrn==0 -> 0 (even if re, we and waddr==0 all hold).
  3. ren==1 and we==1 and waddr==raddrn -> wdata. Same-cycle bypass, purely combinational from the write inputs.
  4. ren==1 -> regs[raddrn].
  5. Otherwise (ren==0) -> 0.
- Both ports are independent. They may read the same address, and both may hit the bypass simultaneously.
- No output depends on prior read history; reads carry no state.
- Reset released mid-stream: the first edge with rst==1 and we==1 performs a normal write. Writes presented while rst==0 are lost and are not replayed.
- Widths: no arithmetic. Addresses are compared at full ADDR_W. No X may propagate to rdata for any defined inputs.

Decomposition:
- Shared defines header:
  - RstEnable = 1'b0 / RstDisable = 1'b1 (active-low polarity for this block).
  - WriteEnable, ReadEnable, ZeroWord, RegBus, RegAddrBus, RegNum = 32, RegNumLog2 = 5, NOPRegAddr = 5'b00000.
- Sub-module: a single read-port mux, regfile_rdport, covering the priority rules above. It is instantiated twice. The storage array stays in regfile.

Test Plan:
- Reset: preload regs via writes, hold rst=0 for 1 edge with we=1, waddr=3, wdata=0xDEADBEEF -> afterwards re1=1/raddr1=3 returns 0x0; reading any reg returns 0x0.
- Write then read: we=1, waddr=5, wdata=0x12345678 at edge N; at N+1 we=0, re1=1, raddr1=5 -> rdata1=0x12345678.
- Bypass: regs[7]=0x1111_1111; in one cycle we=1, waddr=7, wdata=0x2222_2222, re1=re2=1, raddr1=raddr2=7 -> both rdata=0x22222222 combinationally; next cycle with we=0 -> 0x22222222 from the array.
- $0 hardwired: we=1, waddr=0, wdata=0xFFFFFFFF, re1=1, raddr1=0 -> rdata1=0 in the same cycle and all later cycles.
- Read enable off: regs[9]=0xCAFEBABE, re2=0, raddr2=9 -> rdata2=0; set re2=1 -> 0xCAFEBABE.
- Independent ports: regs[1]=0xA, regs[2]=0xB, raddr1=1, raddr2=2, both enabled, with a concurrent write to reg 2 of 0xC -> rdata1=0xA, rdata2=0xC.
